// File: rtl/sprite_pkg.sv
// Shared types and default colours for the sprite compositor.
package sprite_pkg;

  typedef logic [23:0] rgb_t;

  localparam rgb_t DEF_KEY_COLOR = 24'h800080;
  localparam rgb_t DEF_BG_COLOR  = 24'hFFFFFF;

  typedef enum logic {
    IDLE  = 1'b0,
    FLASH = 1'b1
  } flash_state_t;

endpackage

// File: rtl/sprite_compositor_if.sv
// Pixel-stream bus between the sprite position logic (master) and the compositor (slave).
interface sprite_compositor_if #(
  parameter int NUM_SPRITES = 2,
  parameter int ADDR_W      = 12
);

  logic                               pix_valid;
  logic                               frame_start;
  logic [NUM_SPRITES-1:0]             is_sprite;
  logic [NUM_SPRITES-1:0][3:0]        sprite_pose;
  logic [NUM_SPRITES-1:0][ADDR_W-1:0] sprite_addr;
  logic [NUM_SPRITES-1:0]             hit;
  logic [7:0]                         VGA_R;
  logic [7:0]                         VGA_G;
  logic [7:0]                         VGA_B;
  logic                               out_valid;

  modport master (
    output pix_valid, frame_start, is_sprite, sprite_pose, sprite_addr, hit,
    input  VGA_R, VGA_G, VGA_B, out_valid
  );

  modport slave (
    input  pix_valid, frame_start, is_sprite, sprite_pose, sprite_addr, hit,
    output VGA_R, VGA_G, VGA_B, out_valid
  );

endinterface

// File: rtl/sprite_rom_bank.sv
// One sprite's image ROM: synchronous read of {pose, addr} plus a registered invalid-pose flag.
module sprite_rom_bank
  import sprite_pkg::*;
#(
  parameter int   SPRITE_ID = 0,
  parameter int   NUM_POSES = 9,
  parameter int   ADDR_W    = 12,
  parameter rgb_t KEY_COLOR = DEF_KEY_COLOR
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        i_pose,
  input  logic [ADDR_W-1:0] i_addr,
  output rgb_t              o_color,
  output logic              o_bad_pose
);

  localparam int IDX_W = 4 + ADDR_W;

  logic [IDX_W-1:0] w_index;
  rgb_t             r_color;
  logic             r_bad_pose;

  assign w_index = {i_pose, i_addr};

  // Procedurally generated test art: every 16th texel is keyed out, the rest
  // encode sprite, pose and address so each layer is distinguishable on screen.
  function automatic rgb_t texel(input logic [IDX_W-1:0] idx);
    logic [3:0]        pose;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        red;
    logic [7:0]        grn;
    logic [7:0]        blu;
    pose = idx[IDX_W-1 -: 4];
    addr = idx[ADDR_W-1:0];
    red  = 8'hFF ^ 8'(SPRITE_ID * 64);
    grn  = {1'b0, pose, 3'b000} | {5'b00000, addr[2:0]};
    blu  = 8'(addr >> 4);
    if (addr[3:0] == 4'hF) return KEY_COLOR;
    return {red, grn, blu};
  endfunction

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of the order the simulator runs the blocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_color    <= '0;
      r_bad_pose <= 1'b0;
    end else begin
      r_color    <= texel(w_index);
      r_bad_pose <= int'(i_pose) >= NUM_POSES;
    end
  end

  assign o_color    = r_color;
  assign o_bad_pose = r_bad_pose;

endmodule

// File: rtl/sprite_compositor.sv
// Two-stage sprite compositor: ROM read, then lowest-index-opaque priority mux.
// Define SPRITE_FLASH_EN to build the per-sprite damage-flash FSMs.
module sprite_compositor
  import sprite_pkg::*;
#(
  parameter int   NUM_SPRITES  = 2,
  parameter int   NUM_POSES    = 9,
  parameter int   ADDR_W       = 12,
  parameter rgb_t KEY_COLOR    = DEF_KEY_COLOR,
  parameter rgb_t BG_COLOR     = DEF_BG_COLOR,
  parameter int   FLASH_FRAMES = 8
) (
  input logic                Clk,
  input logic                Reset_n,
  sprite_compositor_if.slave bus
);

  rgb_t [NUM_SPRITES-1:0] w_rom_color;
  logic [NUM_SPRITES-1:0] w_rom_bad_pose;
  logic [NUM_SPRITES-1:0] w_hidden;
  logic [NUM_SPRITES-1:0] w_opaque;
  rgb_t                   w_pix;

  logic                   r_s1_valid;
  logic [NUM_SPRITES-1:0] r_s1_is_sprite;
  logic [NUM_SPRITES-1:0] r_s1_hidden;
  logic                   r_out_valid;
  rgb_t                   r_rgb;

  for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : g_rom
    sprite_rom_bank #(
      .SPRITE_ID (gi),
      .NUM_POSES (NUM_POSES),
      .ADDR_W    (ADDR_W),
      .KEY_COLOR (KEY_COLOR)
    ) u_rom (
      .clk        (Clk),
      .rst_n      (Reset_n),
      .i_pose     (bus.sprite_pose[gi]),
      .i_addr     (bus.sprite_addr[gi]),
      .o_color    (w_rom_color[gi]),
      .o_bad_pose (w_rom_bad_pose[gi])
    );
  end

`ifdef SPRITE_FLASH_EN
  localparam int CNT_W = $clog2(FLASH_FRAMES + 1);

  for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : g_flash
    flash_state_t     r_state;
    logic [CNT_W-1:0] r_cnt;

    // A hit always wins over frame_start, so a coincident pair reloads.
    always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
        r_state <= IDLE;
        r_cnt   <= '0;
      end else begin
        unique case (r_state)
          IDLE: begin
            if (bus.hit[gi]) begin
              r_state <= FLASH;
              r_cnt   <= CNT_W'(FLASH_FRAMES);
            end
          end
          FLASH: begin
            if (bus.hit[gi]) begin
              r_cnt <= CNT_W'(FLASH_FRAMES);
            end else if (bus.frame_start) begin
              if (r_cnt == CNT_W'(1)) begin
                r_state <= IDLE;
                r_cnt   <= '0;
              end else begin
                r_cnt <= r_cnt - CNT_W'(1);
              end
            end
          end
        endcase
      end
    end

    assign w_hidden[gi] = (r_state == FLASH) && !r_cnt[0];
  end
`else
  logic w_unused_flash;
  assign w_unused_flash = ^{bus.hit, bus.frame_start};
  assign w_hidden       = '0;
`endif

  // Stage 1: align valid, box and flash visibility with the ROM read.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_s1_valid     <= 1'b0;
      r_s1_is_sprite <= '0;
      r_s1_hidden    <= '0;
    end else begin
      r_s1_valid     <= bus.pix_valid;
      r_s1_is_sprite <= bus.is_sprite;
      r_s1_hidden    <= w_hidden;
    end
  end

  for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : g_opaque
    assign w_opaque[gi] = r_s1_is_sprite[gi] && !w_rom_bad_pose[gi] &&
                          (w_rom_color[gi] != KEY_COLOR) && !r_s1_hidden[gi];
  end

  // NOTE: w_pix is given its default before the loop so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_pix = BG_COLOR;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (w_opaque[i]) w_pix = w_rom_color[i];
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_out_valid <= 1'b0;
      r_rgb       <= '0;
    end else begin
      r_out_valid <= r_s1_valid;
      r_rgb       <= r_s1_valid ? w_pix : '0;
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.VGA_R     = r_rgb[23:16];
  assign bus.VGA_G     = r_rgb[15:8];
  assign bus.VGA_B     = r_rgb[7:0];

endmodule

// File: doc/sprite_compositor.md
SPRITE_COMPOSITOR -- requirements
Module: sprite_compositor

Interface
REQ-001 SHALL have parameter NUM_SPRITES, default 2, meaning the number of independent sprite layers.
REQ-002 SHALL have parameter NUM_POSES, default 9, meaning the pose images per sprite (pose codes 0..NUM_POSES-1).
REQ-003 SHALL have parameter ADDR_W, default 12, meaning the sprite ROM address width.
REQ-004 SHALL have parameter KEY_COLOR, default 24'h800080, meaning the transparent color key.
REQ-005 SHALL have parameter BG_COLOR, default 24'hFFFFFF, meaning the background color.
REQ-006 SHALL have parameter FLASH_FRAMES, default 8, meaning the damage-flash duration in frames.
REQ-007 SHALL have port Clk, input, 1 bit: the single clock.
REQ-008 SHALL have port Reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-009 SHALL have port pix_valid, input, 1 bit: pixel inputs are valid this cycle.
REQ-010 SHALL have port frame_start, input, 1 bit: one-cycle pulse at the start of each frame.
REQ-011 SHALL have port is_sprite, input, NUM_SPRITES bits: the current pixel lies inside sprite i's box.
REQ-012 SHALL have port sprite_pose, input, NUM_SPRITES x 4 bits: the pose code per sprite.
REQ-013 SHALL have port sprite_addr, input, NUM_SPRITES x ADDR_W bits: the ROM address per sprite.
REQ-014 SHALL have port hit, input, NUM_SPRITES bits: one-cycle pulse that starts a damage flash on sprite i.
REQ-015 SHALL have port VGA_R, VGA_G and VGA_B, output, 8 bits each: the registered pixel color.
REQ-016 SHALL have port out_valid, output, 1 bit: VGA_R, VGA_G and VGA_B are valid.

Function
REQ-017 SHALL be a 2-stage pipeline: S1 is the synchronous ROM read with pose/valid/is_sprite delay, and S2 is the composite plus output register. Latency SHALL be exactly 2 cycles.
REQ-018 out_valid SHALL equal pix_valid delayed by 2 cycles; the pipeline SHALL advance every cycle with no stall.
REQ-019 Each sprite SHALL be opaque at a pixel when is_sprite[i]=1, pose < NUM_POSES, ROM color != KEY_COLOR, and the sprite is not flash-hidden.
REQ-020 The output color SHALL be that of the lowest-index opaque sprite; with no opaque sprite, it SHALL be BG_COLOR.
REQ-021 A pose >= NUM_POSES SHALL make the sprite transparent at that pixel; it SHALL NOT alias to another pose.
REQ-022 When out_valid=0, the color outputs SHALL hold 0.
REQ-023 Each sprite SHALL have a flash FSM with states IDLE and FLASH and a frame counter flash_cnt of width $clog2(FLASH_FRAMES+1).
REQ-024 IDLE->FLASH SHALL occur on hit[i], loading flash_cnt=FLASH_FRAMES.
REQ-025 In FLASH, each frame_start SHALL decrement flash_cnt; on frame_start with flash_cnt=1, the FSM SHALL go to IDLE.
REQ-026 In FLASH, the sprite SHALL be hidden on frames where flash_cnt is even and visible on frames where it is odd.
REQ-027 A hit in FLASH SHALL reload flash_cnt=FLASH_FRAMES; hit and frame_start in the same cycle SHALL resolve as a reload, with no decrement.
REQ-028 Flash state changes SHALL take effect only for pixels entering S1 after the change; pixels already in flight SHALL be unaffected.

Reset
REQ-029 Reset_n=0 SHALL asynchronously clear all pipeline registers, out_valid, VGA_R/G/B, flash_cnt and every FSM to IDLE, including mid-flash and mid-frame.
REQ-030 After Reset_n is released, the first valid output SHALL appear 2 cycles after the first pix_valid.

Configuration
REQ-031 Macro SPRITE_FLASH_EN: when defined, the flash FSMs and counters per REQ-023..028 SHALL be built.
REQ-032 Without SPRITE_FLASH_EN, hit SHALL be ignored, no flash logic SHALL be synthesized, and sprites SHALL never be hidden.

Structure
REQ-033 Package sprite_pkg SHALL hold the rgb_t typedef (24-bit), the default KEY_COLOR and BG_COLOR constants, and the flash_state_t enum.
REQ-034 Sub-module sprite_rom_bank SHALL be one synchronous ROM per sprite, indexed by {pose, addr} with a 1-cycle read and an out-of-range pose flag; it SHALL be instantiated NUM_SPRITES times via generate.

Verification
REQ-035 Single sprite, pose 4, opaque ROM value 24'hFF2000, pix_valid=1 -> out_valid and R=FF,G=20,B=00 exactly 2 cycles later.
REQ-036 Sprites 0 and 1 overlap, both opaque -> sprite 0 color; sprite 0 ROM=24'h800080 -> sprite 1 color; both keyed -> FFFFFF.
REQ-037 is_sprite=1 with pose=4'd12 -> FFFFFF; pix_valid dropped for 1 cycle -> out_valid low 2 cycles later, colors 0.
REQ-038 FLASH_FRAMES=4, hit[0] -> sprite 0 hidden/visible alternating over 4 frame_starts, then IDLE and visible; hit coincident with frame_start -> counter reloads to 4.
REQ-039 Reset_n asserted mid-flash and mid-stream -> all outputs 0 immediately (asynchronously), FSM IDLE; build without SPRITE_FLASH_EN -> hit has no visible effect.
